// File: rtl/disp_timing_gen_pkg.sv
// Shared definitions for the disparity raster timing generator.
package disp_timing_gen_pkg;

  // Default widths for timing parameters/counters and disparity pixels.
  localparam int unsigned DefPw = 11;
  localparam int unsigned DefDw = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Default 1920x1080 timing set.
  localparam int unsigned DefHSync  = 4;
  localparam int unsigned DefHBack  = 4;
  localparam int unsigned DefHValid = 1920;
  localparam int unsigned DefHTotal = 1932;
  localparam int unsigned DefVSync  = 1;
  localparam int unsigned DefVTotal = 1080;

endpackage

// File: rtl/disp_param_chk.sv
// Combinational legality check of one raster timing parameter set.
module disp_param_chk
  import disp_timing_gen_pkg::*;
#(
  parameter int unsigned PW = DefPw
) (
  input  logic [PW-1:0] h_sync_i,
  input  logic [PW-1:0] h_back_i,
  input  logic [PW-1:0] h_valid_i,
  input  logic [PW-1:0] h_total_i,
  input  logic [PW-1:0] v_sync_i,
  input  logic [PW-1:0] v_total_i,
  output logic          legal_o
);

  logic [PW+1:0] h_used;

  // Sync+back+valid must leave at least one cycle of front porch; widened to avoid overflow.
  always_comb begin
    h_used  = {2'b00, h_sync_i} + {2'b00, h_back_i} + {2'b00, h_valid_i};
    legal_o = (h_total_i != '0) && (v_total_i != '0) &&
              (h_used < {2'b00, h_total_i}) && (v_sync_i <= v_total_i);
  end

endmodule

// File: rtl/disp_timing_gen.sv
// Raster timing generator: counts a frame from latched parameters, pulls pixels in the active
// window and emits a registered display-style stream with sync strobes and coordinates.
module disp_timing_gen
  import disp_timing_gen_pkg::*;
#(
  parameter int unsigned PW = DefPw,
  parameter int unsigned DW = DefDw
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [PW-1:0] h_sync_i,
  input  logic [PW-1:0] h_back_i,
  input  logic [PW-1:0] h_valid_i,
  input  logic [PW-1:0] h_total_i,
  input  logic [PW-1:0] v_sync_i,
  input  logic [PW-1:0] v_total_i,
  input  logic [DW-1:0] pix_data_i,
  input  logic          pix_valid_i,
  output logic          pix_ready_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [DW-1:0] dout_o,
  output logic [PW-1:0] x_o,
  output logic [PW-1:0] y_o,
  output logic          frame_done_o,
  output logic          underflow_o,
  output logic          param_err_o
);

  state_e        state_q, state_d;
  logic [PW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [PW-1:0] h_sync_q, h_sync_d, h_back_q, h_back_d, h_valid_q, h_valid_d;
  logic [PW-1:0] h_total_q, h_total_d, v_sync_q, v_sync_d, v_total_q, v_total_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [PW-1:0] x_q, x_d, y_q, y_d;
  logic          frame_done_q, frame_done_d, underflow_q, underflow_d;
  logic          param_err_q, param_err_d;

  logic          legal;
  logic          run, hs, vs, act, h_last, v_last, frame_last, load;
  logic [PW+1:0] act_lo, act_hi;

  // Checks the live inputs, since they are only consulted at the moment they get latched.
  disp_param_chk #(
    .PW(PW)
  ) u_param_chk (
    .h_sync_i (h_sync_i),
    .h_back_i (h_back_i),
    .h_valid_i(h_valid_i),
    .h_total_i(h_total_i),
    .v_sync_i (v_sync_i),
    .v_total_i(v_total_i),
    .legal_o  (legal)
  );

  // Decode of the registered counters against the latched parameter set.
  always_comb begin
    run        = (state_q == StRun);
    act_lo     = {2'b00, h_sync_q} + {2'b00, h_back_q};
    act_hi     = act_lo + {2'b00, h_valid_q};
    hs         = run && (h_cnt_q < h_sync_q);
    vs         = run && (v_cnt_q < v_sync_q);
    act        = run && ({2'b00, h_cnt_q} >= act_lo) && ({2'b00, h_cnt_q} < act_hi);
    h_last     = (h_cnt_q == h_total_q - PW'(1));
    v_last     = (v_cnt_q == v_total_q - PW'(1));
    frame_last = run && h_last && v_last;
  end

  assign pix_ready_o = act;

  // Next-state: FSM, counters, parameter latch and registered outputs.
  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    h_sync_d     = h_sync_q;
    h_back_d     = h_back_q;
    h_valid_d    = h_valid_q;
    h_total_d    = h_total_q;
    v_sync_d     = v_sync_q;
    v_total_d    = v_total_q;
    param_err_d  = param_err_q;
    underflow_d  = underflow_q | (act & ~pix_valid_i);
    hsync_d      = hs;
    vsync_d      = vs;
    de_d         = act;
    dout_d       = (act && pix_valid_i) ? pix_data_i : '0;
    x_d          = act ? PW'({2'b00, h_cnt_q} - act_lo) : '0;
    y_d          = act ? v_cnt_q : '0;
    frame_done_d = frame_last;
    load         = 1'b0;

    case (state_q)
      StIdle: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en_i) begin
          load = 1'b1;
          if (legal) begin
            state_d = StRun;
          end else begin
            param_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (h_last) begin
          h_cnt_d = '0;
          v_cnt_d = v_last ? '0 : v_cnt_q + PW'(1);
        end else begin
          h_cnt_d = h_cnt_q + PW'(1);
        end
        // Frame boundary: reload back-to-back without a gap, or drop to idle.
        if (frame_last) begin
          if (en_i) begin
            load = 1'b1;
            if (!legal) begin
              state_d     = StIdle;
              param_err_d = 1'b1;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      h_sync_d  = h_sync_i;
      h_back_d  = h_back_i;
      h_valid_d = h_valid_i;
      h_total_d = h_total_i;
      v_sync_d  = v_sync_i;
      v_total_d = v_total_i;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      h_sync_q     <= '0;
      h_back_q     <= '0;
      h_valid_q    <= '0;
      h_total_q    <= '0;
      v_sync_q     <= '0;
      v_total_q    <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      dout_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      param_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      h_sync_q     <= h_sync_d;
      h_back_q     <= h_back_d;
      h_valid_q    <= h_valid_d;
      h_total_q    <= h_total_d;
      v_sync_q     <= v_sync_d;
      v_total_q    <= v_total_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      dout_q       <= dout_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
      param_err_q  <= param_err_d;
    end
  end

  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign de_o         = de_q;
  assign dout_o       = dout_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign frame_done_o = frame_done_q;
  assign underflow_o  = underflow_q;
  assign param_err_o  = param_err_q;

endmodule

// File: doc/disp_timing_gen.md
# disp_timing_gen

Raster timing generator for the disparity output path. It sits directly downstream of the resolution parameter lookup and consumes its horizontal and vertical timing values. From those values it produces hsync, vsync and data-enable, and pulls disparity pixels from the upstream pixel stream with a valid/ready handshake. The result is a registered, display-style pixel stream with x/y coordinates.

## Interface
Parameters:
- PW, 11, width of all timing parameters and counters
- DW, 8, disparity pixel width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  run request; sampled at frame boundaries
- h_sync, h_back, h_valid, h_total  in  PW each  horizontal timing from parameter lookup
- v_sync, v_total  in  PW each  vertical timing from parameter lookup
- pix_data  in  DW  disparity pixel from upstream buffer
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  pixel consumed this cycle when pix_valid&pix_ready
- hsync, vsync, de  out  1 each  registered timing strobes
- dout  out  DW  registered pixel, 0 when de=0
- x, y  out  PW each  registered coordinate of dout (active-relative)
- frame_done  out  1  one-cycle pulse after last cycle of a frame
- underflow  out  1  sticky: de cycle without pix_valid
- param_err  out  1  sticky: illegal parameter set seen at frame start

## Operation
- FSM states: IDLE, RUN.
- IDLE: counters are held at 0 and all strobes are 0. When en=1, latch all six parameters and check them.
  - Illegal set: h_total==0, v_total==0, h_sync+h_back+h_valid >= h_total, or v_sync > v_total. Sums are computed in PW+2 bits.
  - Illegal set: set param_err and stay in IDLE.
  - Legal set: go to RUN with h_cnt=0, v_cnt=0.
- RUN: h_cnt counts 0..h_total-1 and wraps. On wrap, v_cnt counts 0..v_total-1.
- Decode from the latched parameters:
  - hs = h_cnt < h_sync
  - vs = v_cnt < v_sync
  - act = (h_cnt >= h_sync+h_back) && (h_cnt < h_sync+h_back+h_valid)
- Every line is an active line: there are no vertical blanking lines. vsync is a frame marker that overlaps data.
- pix_ready = (state==RUN) && act. This is combinational from registered counters only, never from pix_valid.
- Active cycle with pix_valid=1: the pixel is consumed and dout<=pix_data.
- Active cycle with pix_valid=0: dout<=0, underflow is set, and counters still advance. Timing never stalls.
- At the last cycle of a frame (h_cnt==h_total-1, v_cnt==v_total-1):
  - frame_done is pulsed on the following cycle.
  - If en=1, the parameters are re-latched and re-checked, and the next frame starts without a gap cycle.
  - Otherwise the FSM returns to IDLE.
- Parameter inputs changing mid-frame have no effect until the next frame boundary.
- en deasserted mid-frame: the current frame completes, then IDLE.
- underflow and param_err clear only on rst.

## Timing
- Reset: all outputs are 0, state is IDLE, and all latched parameters are 0. rst mid-frame aborts on the next edge with no frame_done.
- Latency:
  - hsync/vsync/de/dout/x/y are registered: they show the decode of counter state from the previous cycle. This is 1 cycle after pix_ready.
  - From en=1 in IDLE: the first RUN cycle (h_cnt=0) is the next cycle, and hsync=1 appears one cycle later.
- x = h_cnt-(h_sync+h_back) and y = v_cnt, registered alongside de. Both are 0 when de=0.
- Frame period = h_total*v_total cycles exactly, back-to-back frames included.

## Structure
- Shared package holds:
  - PW and DW defaults
  - FSM state encoding
  - default 1920x1080 timing constants (sync 4, back 4, valid 1920, total 1932, vsync 1, vtotal 1080)
- One sub-module is natural: disp_param_chk, a combinational legality check of a parameter set.
- Counters, FSM and output registers stay in the top level.

## Test plan
- 320x240 (4/4/320/332, 1/240), en held, pix_valid always 1, incrementing data:
  - pix_ready high for h_cnt 8..327 on every line.
  - de high for 320 cycles per line.
  - x runs 0..319 and y runs 0..239.
  - hsync high for 4 cycles per 332-cycle line.
  - vsync high for line 0 only.
  - frame_done every 79680 cycles.
- Throttled source: pix_valid=0 for one active cycle -> dout=0 in that de cycle, underflow=1 and stays set, and line length remains 332.
- Parameter switch: change 320x240 to 640x480 (4/4/640/652, 1/480) mid-frame -> current frame stays 79680 cycles and the next frame is 312960 cycles.
- Illegal set: h_total=300 with h_valid=320 -> param_err=1, state stays IDLE, and pix_ready and de stay 0.
- en dropped at line 100 -> frame completes, a single frame_done pulse, then all strobes 0.
- rst asserted mid-line -> all outputs 0 on the next edge and no frame_done. Re-enabling restarts at h_cnt=0, v_cnt=0.
